// File: rtl/ex_mem_pipe_reg_if.sv
// EX->MEM pipeline bus.
//   *_i : instruction fields presented by the EX stage
//   *_o : registered fields seen by the MEM stage
// Modports:
//   master : EX-side view (drives *_i, observes *_o)
//   slave  : pipeline-register view (consumes *_i, drives *_o)
interface ex_mem_pipe_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WB_W   = 2,
  parameter int unsigned M_W    = 3,
  parameter int unsigned RD_W   = 5
);
  logic              valid_i;
  logic [WB_W-1:0]   wb_i;
  logic [M_W-1:0]    m_i;
  logic [DATA_W-1:0] alu_i;
  logic [DATA_W-1:0] wdata_i;
  logic [RD_W-1:0]   rd_i;

  logic              valid_o;
  logic [WB_W-1:0]   wb_o;
  logic [M_W-1:0]    m_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [DATA_W-1:0] alu_o;
  logic [DATA_W-1:0] wdata_o;
  logic [RD_W-1:0]   rd_o;

  modport master (
    output valid_i, wb_i, m_i, alu_i, wdata_i, rd_i,
    input  valid_o, wb_o, m_o, mem_read_o, mem_write_o, alu_o, wdata_o, rd_o
  );

  modport slave (
    input  valid_i, wb_i, m_i, alu_i, wdata_i, rd_i,
    output valid_o, wb_o, m_o, mem_read_o, mem_write_o, alu_o, wdata_o, rd_o
  );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with valid bit, stall/flush control, bubble gating
// of the WB/M control fields, and saturating stall/flush event counters.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-low reset
//   stall_i      hold pipeline outputs this cycle
//   flush_i      insert a bubble (overrides stall)
//   clr_cnt_i    synchronous clear of both event counters
//   bus          ex_mem_pipe_reg_if.slave : EX fields in, MEM fields out
//   stall_cnt_o  saturating count of stalled edges
//   flush_cnt_o  saturating count of flushed edges
module ex_mem_pipe_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WB_W       = 2,
  parameter int unsigned M_W        = 3,
  parameter int unsigned RD_W       = 5,
  parameter int unsigned MEM_RD_BIT = 1,
  parameter int unsigned MEM_WR_BIT = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic                   clr_cnt_i,
  ex_mem_pipe_reg_if.slave       bus,
  output logic [CNT_W-1:0]       stall_cnt_o,
  output logic [CNT_W-1:0]       flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              r_valid;
  logic [WB_W-1:0]   r_wb;
  logic [M_W-1:0]    r_m;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_wdata;
  logic [RD_W-1:0]   r_rd;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_stall_ev;

  // A stall only counts when it is not overridden by a flush.
  assign w_stall_ev = stall_i & ~flush_i;

  // Pipeline fields: flush > stall > load; control zeroed for invalid slots.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_wb    <= '0;
      r_m     <= '0;
      r_alu   <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_wb    <= '0;
      r_m     <= '0;
      r_alu   <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
    end else if (!stall_i) begin
      r_valid <= bus.valid_i;
      r_wb    <= bus.valid_i ? bus.wb_i : '0;
      r_m     <= bus.valid_i ? bus.m_i  : '0;
      r_alu   <= bus.alu_i;
      r_wdata <= bus.wdata_i;
      r_rd    <= bus.rd_i;
    end
  end

  // Event counters: clear wins over increment; saturate at all-ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (clr_cnt_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_ev && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (flush_i && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.valid_o = r_valid;
  assign bus.wb_o    = r_wb;
  assign bus.m_o     = r_m;
  assign bus.alu_o   = r_alu;
  assign bus.wdata_o = r_wdata;
  assign bus.rd_o    = r_rd;

  // Memory strobes are plain slices of the registered M field.
  assign bus.mem_read_o  = r_m[MEM_RD_BIT];
  assign bus.mem_write_o = r_m[MEM_WR_BIT];

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: a default-width instance for pipeline
// behaviour and a CNT_W=2 instance for counter saturation.
module tb_ex_mem_pipe_reg;

  logic clk = 1'b0;
  logic rst_n;
  logic stall, flush, clr;
  logic stall2, clr2;
  logic [15:0] scnt, fcnt;
  logic [1:0]  scnt2, fcnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_reg_if #(.DATA_W(32), .WB_W(2), .M_W(3), .RD_W(5)) bus ();
  ex_mem_pipe_reg_if #(.DATA_W(32), .WB_W(2), .M_W(3), .RD_W(5)) bus2 ();

  ex_mem_pipe_reg #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush),
    .clr_cnt_i(clr), .bus(bus.slave), .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  ex_mem_pipe_reg #(.CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst_n), .stall_i(stall2), .flush_i(1'b0),
    .clr_cnt_i(clr2), .bus(bus2.slave), .stall_cnt_o(scnt2), .flush_cnt_o(fcnt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [2:0] m,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
    bus.valid_i = v; bus.wb_i = wb; bus.m_i = m;
    bus.alu_i = alu; bus.wdata_i = wd; bus.rd_i = rd;
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; flush = 0; clr = 0; stall2 = 0; clr2 = 0;
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    bus2.valid_i = 0; bus2.wb_i = 0; bus2.m_i = 0;
    bus2.alu_i = 0; bus2.wdata_i = 0; bus2.rd_i = 0;

    // Reset state
    tick(); tick();
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_wb",    64'(bus.wb_o),    64'd0);
    chk("rst_m",     64'(bus.m_o),     64'd0);
    chk("rst_alu",   64'(bus.alu_o),   64'd0);
    chk("rst_scnt",  64'(scnt),        64'd0);
    chk("rst_fcnt",  64'(fcnt),        64'd0);

    // First capture after release
    rst_n = 1'b1;
    drive(1'b1, 2'b01, 3'b010, 32'h1234, 32'hDEAD, 5'd7);
    tick();
    chk("first_alu",   64'(bus.alu_o),      64'h1234);
    chk("first_valid", 64'(bus.valid_o),    64'd1);
    chk("first_rd",    64'(bus.rd_o),       64'd7);
    chk("first_wdata", 64'(bus.wdata_o),    64'hDEAD);
    chk("first_mrd",   64'(bus.mem_read_o), 64'd1);

    // Async reset asserted mid-stall, between edges
    stall = 1;
    tick();
    chk("stall_pre_rst", 64'(scnt), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(bus.valid_o), 64'd0);
    chk("async_alu",   64'(bus.alu_o),   64'd0);
    chk("async_rd",    64'(bus.rd_o),    64'd0);
    chk("async_scnt",  64'(scnt),        64'd0);
    tick();
    rst_n = 1'b1; stall = 0;

    // Back-to-back stream, loads with one edge of latency
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 2'b10, 3'b010, 32'(i), 32'(i * 16), 5'(i));
      tick();
      chk("stream_alu",  64'(bus.alu_o),       64'(i));
      chk("stream_rd",   64'(bus.rd_o),        64'(i));
      chk("stream_mrd",  64'(bus.mem_read_o),  64'd1);
      chk("stream_mwr",  64'(bus.mem_write_o), 64'd0);
    end

    // Stall three edges with changing inputs: outputs frozen on instr 4
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b01, 3'b001, 32'(100 + k), 32'h77, 5'd20);
      tick();
      chk("stall_alu", 64'(bus.alu_o), 64'd4);
      chk("stall_rd",  64'(bus.rd_o),  64'd4);
      chk("stall_wb",  64'(bus.wb_o),  64'd2);
    end
    chk("stall_cnt", 64'(scnt), 64'd3);
    stall = 0;
    drive(1'b1, 2'b01, 3'b001, 32'h55, 32'h66, 5'd11);
    tick();
    chk("release_alu", 64'(bus.alu_o),       64'h55);
    chk("release_rd",  64'(bus.rd_o),        64'd11);
    chk("release_mwr", 64'(bus.mem_write_o), 64'd1);

    // Flush overrides a simultaneous stall
    stall = 1; flush = 1;
    drive(1'b1, 2'b11, 3'b011, 32'h99, 32'h88, 5'd9);
    tick();
    chk("flush_valid", 64'(bus.valid_o), 64'd0);
    chk("flush_wb",    64'(bus.wb_o),    64'd0);
    chk("flush_m",     64'(bus.m_o),     64'd0);
    chk("flush_rd",    64'(bus.rd_o),    64'd0);
    chk("flush_alu",   64'(bus.alu_o),   64'd0);
    chk("flush_fcnt",  64'(fcnt),        64'd1);
    chk("flush_scnt",  64'(scnt),        64'd3);
    stall = 0; flush = 0;

    // Bubble gating: invalid slot loads data but never control
    drive(1'b0, 2'b11, 3'b001, 32'hA5, 32'h5A, 5'd3);
    tick();
    chk("bub_valid", 64'(bus.valid_o),     64'd0);
    chk("bub_wb",    64'(bus.wb_o),        64'd0);
    chk("bub_mwr",   64'(bus.mem_write_o), 64'd0);
    chk("bub_alu",   64'(bus.alu_o),       64'hA5);
    chk("bub_rd",    64'(bus.rd_o),        64'd3);

    // Counter clear on the wide instance leaves the pipeline untouched
    clr = 1;
    tick();
    clr = 0;
    chk("clr_scnt", 64'(scnt), 64'd0);
    chk("clr_fcnt", 64'(fcnt), 64'd0);
    chk("clr_alu",  64'(bus.alu_o), 64'hA5);

    // Saturation on the CNT_W=2 instance
    stall2 = 1;
    tick(); tick();
    chk("sat_two", 64'(scnt2), 64'd2);
    tick(); tick(); tick();
    chk("sat_hold", 64'(scnt2), 64'd3);
    chk("sat_fcnt", 64'(fcnt2), 64'd0);
    clr2 = 1;
    tick();
    chk("sat_clr", 64'(scnt2), 64'd0);
    clr2 = 0; stall2 = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
